// File: rtl/uart_pkg.sv
// Shared UART types, constants and the clocks-per-bit helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } uart_rx_state_t;

   // Rounded clocks per bit; shared with the transmitter side.
   function automatic int uart_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous single-bit input, with a selectable reset value.
// Latency N cycles; no flow control.
module uart_sync #(
   parameter int   N       = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic [N-1:0] r_ff;

   if (N < 2) begin : g_bad_n
      $error("uart_sync: N must be at least 2");
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ff <= {N{RST_VAL}};
      end else begin
         r_ff <= {r_ff[N-2:0], i_async};
      end
   end

   assign o_sync = r_ff[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (8E1 with UART_RX_PARITY_EN), mid-bit sampling, byte out on a single-entry valid/ready register.
// A byte completing while the register is full and not being accepted is dropped with an overrun pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 153_600,
   parameter int BAUD        = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       parity_err_o
);

   localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0]         CNT_HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0]         CNT_FULL = CW'(DIV - 1);
   localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

   if (DIV < 4) begin : g_bad_div
      $error("uart_rx: clocks per bit must be at least 4");
   end

   uart_rx_state_t            r_state;
   uart_rx_state_t            w_state_nxt;
   logic [CW-1:0]             r_cnt;
   logic [CW-1:0]             w_cnt_nxt;
   logic [UART_IDX_W-1:0]     r_idx;
   logic [UART_IDX_W-1:0]     w_idx_nxt;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] w_shift_nxt;
   logic [7:0]                r_data;
   logic                      r_valid;
   logic                      r_frame_err;
   logic                      r_overrun;
   logic                      w_rx_s;
   logic                      w_cnt_zero;
   logic                      w_deliver;
   logic                      w_frame_err;
   logic                      w_par_bad;
`ifdef UART_RX_PARITY_EN
   logic                      r_par;
   logic                      w_par_nxt;
   logic                      w_par_err;
   logic                      r_par_err;
`endif

   uart_sync #(
      .N       (2),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (rx_i),
      .o_sync  (w_rx_s)
   );

   assign w_cnt_zero = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
   // Even parity: the received parity bit must equal the XOR of the data bits.
   assign w_par_bad = (^r_shift) != r_par;
`else
   assign w_par_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
`ifdef UART_RX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_deliver   = 1'b0;
      w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt   = r_par;
      w_par_err   = 1'b0;
`endif

      case (r_state)
         ST_IDLE: begin
            if (!w_rx_s) begin
               w_cnt_nxt   = CNT_HALF;
               w_state_nxt = ST_START;
            end
         end

         ST_START: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else if (!w_rx_s) begin
               w_cnt_nxt   = CNT_FULL;
               w_idx_nxt   = '0;
               w_state_nxt = ST_DATA;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_DATA: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_shift_nxt[r_idx] = w_rx_s;
               w_cnt_nxt          = CNT_FULL;
               if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end else begin
                  w_idx_nxt = r_idx + UART_IDX_W'(1);
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_par_nxt   = w_rx_s;
               w_cnt_nxt   = CNT_FULL;
               w_state_nxt = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else if (!w_rx_s) begin
               // Framing error wins over parity; BREAK absorbs a held-low line.
               w_frame_err = 1'b1;
               w_state_nxt = ST_BREAK;
            end else if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
               w_par_err   = 1'b1;
`endif
               w_state_nxt = ST_IDLE;
            end else begin
               w_deliver   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end

         ST_BREAK: begin
            if (w_rx_s) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Holding register: a same-cycle accept frees the slot for the new byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err   <= 1'b0;
`endif
      end else begin
         r_frame_err <= w_frame_err;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err   <= w_par_err;
`endif
         if (w_deliver) begin
            if (!r_valid || ready_i) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = r_par_err;
`else
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: reception, timing, glitch, framing, overrun, mid-frame reset.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int BIT_CYC = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       frame_err_o;
   logic       overrun_o;
   logic       parity_err_o;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int n_vhi  = 0;
   int n_ferr = 0;
   int n_ovr  = 0;
   int n_perr = 0;
   int ovr_t  = 0;
   logic [7:0] rx_q[$];
   int         rx_t[$];

   uart_rx dut (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .frame_err_o  (frame_err_o),
      .overrun_o    (overrun_o),
      .parity_err_o (parity_err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_o) n_vhi++;
      if (valid_o && ready_i) begin
         rx_q.push_back(data_o);
         rx_t.push_back(cyc);
      end
      if (frame_err_o) n_ferr++;
      if (overrun_o) begin
         n_ovr++;
         ovr_t = cyc;
      end
      if (parity_err_o) n_perr++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one 10-bit frame; cs is the cycle count just before the start bit's first sampling edge.
   task automatic send_frame(input logic [7:0] b, input logic stop, output int cs);
      rx_i = 1'b0;
      cs   = cyc;
      tick(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         tick(BIT_CYC);
      end
      rx_i = stop;
      tick(BIT_CYC);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int cs, cs2, q0, f0, o0;

      rst     = 1'b1;
      rx_i    = 1'b1;
      ready_i = 1'b1;
      tick(3);
      chk("rst_data",  32'(data_o), 32'h00);
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_ferr",  32'(frame_err_o), 32'h0);
      chk("rst_ovr",   32'(overrun_o), 32'h0);
      chk("rst_perr",  32'(parity_err_o), 32'h0);
      rst = 1'b0;
      tick(20);

      // Basic receive with exact delivery timing
      q0 = rx_q.size();
      n_vhi = 0;
      send_frame(8'hAA, 1'b1, cs);
      tick(20);
      send_frame(8'h33, 1'b1, cs2);
      tick(20);
      chk("basic_cnt", 32'(rx_q.size() - q0), 32'd2);
      if (rx_q.size() >= q0 + 2) begin
         chk("basic_b0", 32'(rx_q[q0]), 32'hAA);
         chk("basic_b1", 32'(rx_q[q0+1]), 32'h33);
         chk("basic_t0", 32'(rx_t[q0]), 32'(cs + 155));
      end
      chk("basic_vhi",  32'(n_vhi), 32'd2);
      chk("basic_ferr", 32'(n_ferr), 32'd0);
      chk("basic_ovr",  32'(n_ovr), 32'd0);
      chk("basic_perr", 32'(n_perr), 32'd0);

      // Back-to-back frames
      q0 = rx_q.size();
      send_frame(8'h3C, 1'b1, cs);
      send_frame(8'h3C, 1'b1, cs2);
      tick(20);
      chk("b2b_cnt", 32'(rx_q.size() - q0), 32'd2);
      if (rx_q.size() >= q0 + 2) begin
         chk("b2b_b0",  32'(rx_q[q0]), 32'h3C);
         chk("b2b_b1",  32'(rx_q[q0+1]), 32'h3C);
         chk("b2b_gap", 32'(rx_t[q0+1] - rx_t[q0]), 32'd160);
      end

      // Glitch rejection
      q0 = rx_q.size();
      rx_i = 1'b0;
      tick(4);
      rx_i = 1'b1;
      tick(30);
      chk("glitch_none",  32'(rx_q.size() - q0), 32'd0);
      chk("glitch_idle",  32'(dut.r_state), 32'(ST_IDLE));
      send_frame(8'h55, 1'b1, cs);
      tick(20);
      chk("glitch_next_cnt", 32'(rx_q.size() - q0), 32'd1);
      if (rx_q.size() > q0) chk("glitch_next_b", 32'(rx_q[q0]), 32'h55);

      // Framing error with held-low line
      q0 = rx_q.size();
      f0 = n_ferr;
      send_frame(8'h81, 1'b0, cs);
      tick(40);
      rx_i = 1'b1;
      tick(30);
      chk("ferr_pulses", 32'(n_ferr - f0), 32'd1);
      chk("ferr_none",   32'(rx_q.size() - q0), 32'd0);
      send_frame(8'h12, 1'b1, cs);
      tick(20);
      chk("ferr_next_cnt", 32'(rx_q.size() - q0), 32'd1);
      if (rx_q.size() > q0) chk("ferr_next_b", 32'(rx_q[q0]), 32'h12);

      // Overrun
      q0 = rx_q.size();
      o0 = n_ovr;
      ready_i = 1'b0;
      send_frame(8'h01, 1'b1, cs);
      tick(10);
      send_frame(8'h02, 1'b1, cs2);
      tick(10);
      chk("ovr_data",   32'(data_o), 32'h01);
      chk("ovr_valid",  32'(valid_o), 32'h1);
      chk("ovr_pulses", 32'(n_ovr - o0), 32'd1);
      chk("ovr_time",   32'(ovr_t), 32'(cs2 + 155));
      ready_i = 1'b1;
      tick(6);
      chk("ovr_acc_cnt", 32'(rx_q.size() - q0), 32'd1);
      if (rx_q.size() > q0) chk("ovr_acc_b", 32'(rx_q[q0]), 32'h01);
      chk("ovr_valid_clr", 32'(valid_o), 32'h0);

      // Reset after data bit 3 of 0xF0
      q0 = rx_q.size();
      f0 = n_ferr;
      rx_i = 1'b0;
      tick(BIT_CYC);
      for (int i = 0; i < 4; i++) begin
         rx_i = 1'(8'hF0 >> i);
         tick(BIT_CYC);
      end
      rx_i = 1'b1;
      rst  = 1'b1;
      tick(1);
      rst  = 1'b0;
      chk("mrst_data",  32'(data_o), 32'h00);
      chk("mrst_valid", 32'(valid_o), 32'h0);
      chk("mrst_state", 32'(dut.r_state), 32'(ST_IDLE));
      chk("mrst_cnt",   32'(dut.r_cnt), 32'h0);
      tick(200);
      chk("mrst_none", 32'(rx_q.size() - q0), 32'd0);
      chk("mrst_ferr", 32'(n_ferr - f0), 32'd0);
      send_frame(8'h3C, 1'b1, cs);
      tick(20);
      chk("mrst_next_cnt", 32'(rx_q.size() - q0), 32'd1);
      if (rx_q.size() > q0) chk("mrst_next_b", 32'(rx_q[q0]), 32'h3C);
      chk("final_perr", 32'(n_perr), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Synthesizable UART receiver: the RTL consumer of the serial line that `uart_tx_bfm` drives. It synchronizes the asynchronous `rx_i` line, detects and validates start bits, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit and presents each received byte on a single-entry valid/ready output register. It sits between the pad and the byte-level logic, and replaces `uart_rx_bfm` when the bench runs against RTL.

## Interface
- `CLK_FREQ_HZ`, default 153_600: system clock frequency.
- `BAUD`, default 9600: line rate.
- Derived `DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD` clocks per bit. Elaboration error if `DIV < 4`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_i`  in  1  serial line, asynchronous, idles high.
- `data_o`  out  8  received byte; stable while `valid_o`=1.
- `valid_o`  out  1  byte available; held until accepted.
- `ready_i`  in  1  consumer accepts the byte when `valid_o && ready_i`.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun_o`  out  1  one-cycle pulse: a completed byte was dropped because the holding register was full.
- `parity_err_o`  out  1  one-cycle pulse: parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.

## Operation
- **Synchronizer:** two flops on `rx_i`, both reset to 1. All decisions use the second flop (`rx_s`).
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
- **IDLE:** on `rx_s`=0, load the bit counter with `DIV/2 - 1` (integer division) and enter START.
- **START:**
  - When the counter reaches 0, sample `rx_s`.
  - If 0: load the counter with `DIV-1`, clear the bit index, enter DATA.
  - If 1: glitch; return to IDLE with no output.
- **DATA:**
  - At each counter expiry, shift `rx_s` into the shift register at bit index (LSB first) and reload `DIV-1`.
  - After index 7, go to PARITY (macro defined) or STOP.
- **STOP:** at counter expiry, sample `rx_s`.
  - **Sample = 1, no parity error:** deliver the byte (see hand-off) and go to IDLE immediately, i.e. mid stop bit. This allows back-to-back frames.
  - **Sample = 1, parity error:** pulse `parity_err_o`, drop the byte, go to IDLE.
  - **Sample = 0:** pulse `frame_err_o`, drop the byte, enter BREAK.
- **BREAK:** wait for `rx_s`=1, then go to IDLE. A held-low line yields exactly one `frame_err_o` pulse.
- **Output hand-off:**
  - **Register empty, or being accepted this cycle** (`valid_o && ready_i`): the new byte loads `data_o` and `valid_o` stays or becomes 1. Simultaneous accept and deliver loses nothing.
  - **Register full and not accepted:** pulse `overrun_o`. The new byte is dropped; the held byte is unchanged.
  - **Accept without new byte:** `valid_o` goes to 0 the next cycle.
- **Reset, including mid-frame:**
  - FSM to IDLE, counters to 0, synchronizer to 1.
  - `data_o`=0x00, `valid_o`=0, `frame_err_o`=0, `overrun_o`=0, `parity_err_o`=0.
  - The partial frame is discarded. A line still low after reset is treated as a new start bit.

## Timing
- Let cycle 0 be the first rising edge at which `rx_i` is sampled 0.
  - IDLE sees `rx_s`=0 at edge 2.
  - The start sample is taken at edge `2 + DIV/2`.
  - Data bit k is sampled at edge `2 + DIV/2 + (k+1)*DIV`.
  - The stop bit is sampled at edge `2 + DIV/2 + 9*DIV`; parity adds `DIV`.
- `valid_o` (or an error pulse) is visible from the edge after the stop sample.
- Counter width is `$clog2(DIV)`; the counter never wraps outside a reload.
- `data_o` changes only on a load. It never changes while `valid_o`=1 and `ready_i`=0.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - A 9th bit is sampled in PARITY, one `DIV` after bit 7.
  - It must equal even parity (XOR of the data bits).
  - A mismatch pulses `parity_err_o` at the stop-bit sample edge and drops the byte. A stop-bit error takes precedence, so only `frame_err_o` pulses.
- **Undefined:** no PARITY state, frame is 10 bits, `parity_err_o` is constant 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - `UART_DATA_BITS = 8`;
  - function `uart_div(clk_hz, baud)`, shared with a future `uart_tx`.
- Sub-module `uart_sync`: parameterized N-flop synchronizer with reset value, instantiated with N=2 and reset value 1.

## Test plan
All scenarios use `DIV` = 16 (default parameters) and drive `rx_i` with `uart_tx_bfm` unless stated.
- **Basic receive:** send 0xAA, then 0x33, with `ready_i`=1 → `data_o` 0xAA then 0x33, each `valid_o` for one cycle, no error pulses.
- **Back-to-back:** two 0x3C frames with no idle gap → two deliveries of 0x3C. The second `valid_o` comes exactly 160 cycles after the first.
- **Glitch rejection:** `rx_i` low for 4 cycles, then high → no `valid_o`, FSM back in IDLE, then a following 0x55 is received correctly.
- **Framing error:** 0x81 sent with the stop bit forced 0, then the line held low for 40 cycles → one `frame_err_o` pulse, no `valid_o`. A subsequent 0x12 is received.
- **Overrun:** `ready_i`=0 while 0x01 then 0x02 are sent → `data_o`=0x01 held, one `overrun_o` pulse at the second stop sample. Raising `ready_i` yields 0x01 only.
- **Reset mid-frame:** assert `rst` for 1 cycle after data bit 3 of 0xF0 → all outputs reset, no delivery. A following 0x3C is received.
